// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and defaults for the ADC capture write sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adc_cap_pkg;

  localparam int LEN_DEF = 800;
  localparam int AW_DEF  = 10;
  localparam int DW_DEF  = 8;

  // Capture sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARM,
    ST_POST,
    ST_DONE
  } cap_state_e;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// RAM write port plus frame status bundle from the capture sequencer to the RAM/LCD side.
// Latency: n/a (wires only).
// Backpressure: none; the RAM accepts a write on every clk.
interface adc_capture_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done;
  logic [AW-1:0] start_addr;
  logic          triggered;
  logic          busy;

  modport master (
    output wr_en, wr_addr, wr_data, frame_done, start_addr, triggered, busy
  );

  modport slave (
    input wr_en, wr_addr, wr_data, frame_done, start_addr, triggered, busy
  );
endinterface

// File: rtl/adc_trig_detect.sv
// Level/slope trigger comparator on the decimated sample stream.
// Latency: hit is combinational in the tick cycle; prev loads on the same edge.
// Backpressure: none; samples are never stalled.
module adc_trig_detect #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          tick_i,
  input  logic          arm_i,
  input  logic [DW-1:0] sample_i,
  input  logic [DW-1:0] level_i,
  input  logic          slope_i,
  output logic          hit_o
);

  logic [DW-1:0] prev_q;
  logic          prev_valid_q;
  logic          rise;
  logic          fall;

  // Previous-sample register: emptied at frame start, loaded on every decimated sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (clear_i) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (tick_i) begin
      prev_q       <= sample_i;
      prev_valid_q <= 1'b1;
    end
  end

  // Crossing compare; only meaningful once a previous sample exists
  always_comb begin
    rise  = (prev_q < level_i) && (sample_i >= level_i);
    fall  = (prev_q > level_i) && (sample_i <= level_i);
    hit_o = tick_i && arm_i && prev_valid_q && (slope_i ? fall : rise);
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Decimating circular-buffer write sequencer with pre-trigger history; optional auto trigger via ADC_AUTO_TRIG_EN.
// Latency: a sample taken on a decimation tick is written to the RAM one clk later.
// Backpressure: none; run=0 aborts to IDLE next clk and drops any pending write.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int LEN          = LEN_DEF,
  parameter int PRE_LEN      = 100,
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int DIV_W        = 16,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    adc_data_i,
  input  logic             run_i,
  input  logic             rearm_i,
  input  logic [DW-1:0]    trig_level_i,
  input  logic             trig_slope_i,
  input  logic [DIV_W-1:0] dec_div_i,
  adc_capture_ctrl_if.master cap_o
);

  localparam int            POST_N    = LEN - PRE_LEN - 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);
  localparam logic [AW-1:0] PRE_END   = AW'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
  localparam logic [AW-1:0] POST_END  = AW'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [AW:0]   LEN_W     = (AW + 1)'(LEN);
  localparam logic [AW:0]   BACK_W    = (AW + 1)'(LEN - PRE_LEN);
  localparam cap_state_e    FIRST_ST  = (PRE_LEN == 0) ? ST_ARM : ST_PRE;
  localparam cap_state_e    HIT_ST    = (POST_N == 0) ? ST_DONE : ST_POST;

  cap_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, div_q;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    seg_cnt_q, seg_cnt_d;
  logic [AW-1:0]    trig_addr_q, trig_src;
  logic [AW-1:0]    start_addr_q, start_d;
  logic [AW:0]      start_sum;
  logic [AW-1:0]    wr_addr_q;
  logic [DW-1:0]    wr_data_q;
  logic             wr_en_q, frame_done_q, triggered_q, busy_q;
  logic             busy_st, tick, start_frame, hit, auto_hit, hit_any;

  assign busy_st = (state_q == ST_PRE) || (state_q == ST_ARM) || (state_q == ST_POST);
  assign tick    = busy_st && (cnt_q == div_q);
  assign hit_any = hit || auto_hit;

  adc_trig_detect #(.DW(DW)) u_trig (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (start_frame),
    .tick_i   (tick),
    .arm_i    (state_q == ST_ARM),
    .sample_i (adc_data_i),
    .level_i  (trig_level_i),
    .slope_i  (trig_slope_i),
    .hit_o    (hit)
  );

`ifdef ADC_AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] arm_cnt_q;

  assign auto_hit = (state_q == ST_ARM) && tick && (arm_cnt_q == TW'(AUTO_TIMEOUT));

  // ARM sample counter; held at zero outside ARM so every ARM entry starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt_q <= '0;
    end else if (state_q != ST_ARM) begin
      arm_cnt_q <= '0;
    end else if (tick) begin
      arm_cnt_q <= arm_cnt_q + TW'(1);
    end
  end
`else
  assign auto_hit = 1'b0;
`endif

  // Next-state decode; run=0 overrides everything including rearm
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    unique case (state_q)
      ST_IDLE: if (run_i) begin state_d = FIRST_ST; start_frame = 1'b1; end
      ST_PRE:  if (tick && (seg_cnt_q == PRE_END)) state_d = ST_ARM;
      ST_ARM:  if (hit_any) state_d = HIT_ST;
      ST_POST: if (tick && (seg_cnt_q == POST_END)) state_d = ST_DONE;
      ST_DONE: if (rearm_i) begin state_d = FIRST_ST; start_frame = 1'b1; end
      default: state_d = ST_IDLE;
    endcase
    if (!run_i) begin
      state_d     = ST_IDLE;
      start_frame = 1'b0;
    end
  end

  // Pointer wrap, segment counter and oldest-sample address (modulo LEN by compare-and-subtract)
  always_comb begin
    ptr_d     = (ptr_q == LAST_ADDR) ? '0 : ptr_q + AW'(1);
    seg_cnt_d = ((state_d != state_q) || (state_q == ST_ARM)) ? '0 : seg_cnt_q + AW'(1);
    trig_src  = (state_q == ST_ARM) ? ptr_q : trig_addr_q;
    start_sum = {1'b0, trig_src} + BACK_W;
    start_d   = (start_sum >= LEN_W) ? AW'(start_sum - LEN_W) : AW'(start_sum);
  end

  // Sequencer state, decimation, write pipeline and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      ptr_q        <= '0;
      seg_cnt_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      triggered_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      // divider value is only picked up at a wrap so a live change never splits a period
      if (!busy_st || tick) begin
        cnt_q <= '0;
        div_q <= dec_div_i;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
      wr_en_q <= tick && run_i;
      if (tick) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= adc_data_i;
        ptr_q     <= ptr_d;
        seg_cnt_q <= seg_cnt_d;
      end
      if (start_frame) begin
        ptr_q     <= '0;
        seg_cnt_q <= '0;
      end
      if ((state_q == ST_ARM) && hit_any) trig_addr_q <= ptr_q;
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) start_addr_q <= start_d;
      frame_done_q <= (state_d == ST_DONE);
      triggered_q  <= (state_d == ST_POST) || (state_d == ST_DONE);
      busy_q       <= (state_d == ST_PRE) || (state_d == ST_ARM) || (state_d == ST_POST);
    end
  end

  assign cap_o.wr_en      = wr_en_q;
  assign cap_o.wr_addr    = wr_addr_q;
  assign cap_o.wr_data    = wr_data_q;
  assign cap_o.frame_done = frame_done_q;
  assign cap_o.start_addr = start_addr_q;
  assign cap_o.triggered  = triggered_q;
  assign cap_o.busy       = busy_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: expected writes queued as samples are driven.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_capture_ctrl;

  localparam int LEN = 800, PRE_LEN = 100, AW = 10, DW = 8, DIV_W = 16;
  localparam int P_RAMP = 0, P_LATE = 1, P_FALL = 2, P_CONST = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW-1:0]    adc_data = '0;
  logic             run = 1'b0;
  logic             rearm = 1'b0;
  logic [DW-1:0]    trig_level = 8'd128;
  logic             trig_slope = 1'b0;
  logic [DIV_W-1:0] dec_div = '0;

  adc_capture_ctrl_if #(.AW(AW), .DW(DW)) cap_if ();

  adc_capture_ctrl #(
    .LEN(LEN), .PRE_LEN(PRE_LEN), .AW(AW), .DW(DW), .DIV_W(DIV_W), .AUTO_TIMEOUT(65535)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_data_i   (adc_data),
    .run_i        (run),
    .rearm_i      (rearm),
    .trig_level_i (trig_level),
    .trig_slope_i (trig_slope),
    .dec_div_i    (dec_div),
    .cap_o        (cap_if)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  int gap_exp = 1;
  bit gap_en = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sample_val(input int pat, input int k);
    case (pat)
      P_RAMP: return k % 256;
      P_LATE: return (k < 900) ? 0 : (k - 900) % 256;
      P_FALL: begin
        if (k < 110) return 128;
        else if (k == 110) return 130;
        else if (k == 111) return 129;
        else if (k == 112) return 128;
        else return 127;
      end
      default: return 200;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every RAM write must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && cap_if.wr_en) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_wr", int'(cap_if.wr_addr), -1);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", int'(cap_if.wr_addr), e.addr);
        chk("wr_data", int'(cap_if.wr_data), e.data);
      end
      if (gap_en && last_wr_cyc >= 0) chk("wr_gap", cyc - last_wr_cyc, gap_exp);
      last_wr_cyc = cyc;
    end
  end

  // Drives one frame sample by sample, holding each for a full decimation period.
  task automatic run_frame(input int pat, input int div, input int level, input bit slope,
                           input int exp_trig, input int max_k, input int rearm_k,
                           input int abort_k);
    int v, prev, trig;
    bit pvld, done;
    trig = -1; prev = 0; pvld = 1'b0; done = 1'b0;
    dec_div    = DIV_W'(div);
    trig_level = DW'(level);
    trig_slope = slope;
    @(posedge clk); #1;
    rearm = 1'b0;
    chk("start_frame_done", int'(cap_if.frame_done), 0);
    chk("start_busy", int'(cap_if.busy), 1);
    gap_exp = div + 1; last_wr_cyc = -1; gap_en = 1'b1;
    for (int k = 0; k < max_k && !done; k++) begin
      @(negedge clk);
      if (k == abort_k) begin
        run = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", int'(cap_if.busy), 0);
        chk("abort_triggered", int'(cap_if.triggered), 0);
        chk("abort_wr_en", int'(cap_if.wr_en), 0);
        gap_en = 1'b0;
        return;
      end
      v = sample_val(pat, k);
      adc_data = DW'(v);
      sb_q.push_back('{k % LEN, v});
      if (k >= PRE_LEN && trig < 0 && pvld &&
          (slope ? (prev > level && v <= level) : (prev < level && v >= level)))
        trig = k;
      prev = v; pvld = 1'b1;
      if (trig >= 0 && k == trig + LEN - PRE_LEN - 1) done = 1'b1;
      if (k == rearm_k) rearm = 1'b1;
      repeat (div + 1) begin
        @(posedge clk); #1;
        rearm = 1'b0;
      end
    end
    gap_en = 1'b0;
    @(negedge clk); #1;
    chk("sb_drained", sb_q.size(), 0);
    if (exp_trig >= 0) begin
      chk("frame_done", int'(cap_if.frame_done), 1);
      chk("triggered", int'(cap_if.triggered), 1);
      chk("done_busy", int'(cap_if.busy), 0);
      chk("start_addr", int'(cap_if.start_addr), (exp_trig + LEN - PRE_LEN) % LEN);
      repeat (10) @(negedge clk);
      #1;
      chk("done_hold", int'(cap_if.frame_done), 1);
    end else begin
      chk("armed_busy", int'(cap_if.busy), 1);
      chk("armed_triggered", int'(cap_if.triggered), 0);
      chk("armed_frame_done", int'(cap_if.frame_done), 0);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(cap_if.wr_en), 0);
    chk("rst_frame_done", int'(cap_if.frame_done), 0);
    chk("rst_triggered", int'(cap_if.triggered), 0);
    chk("rst_busy", int'(cap_if.busy), 0);
    chk("rst_start_addr", int'(cap_if.start_addr), 0);
    chk("rst_wr_addr", int'(cap_if.wr_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(cap_if.busy), 0);

    // ramp, rising through 128; a rearm pulse in POST must be ignored
    run = 1'b1;
    run_frame(P_RAMP, 0, 128, 1'b0, 128, 2000, 200, -1);

    // rearm from DONE, divide by 4, trigger late enough that ARM wraps 799 -> 0
    rearm = 1'b1;
    run_frame(P_LATE, 3, 128, 1'b0, 1028, 3000, -1, -1);

    // falling slope; level-equal samples with level-equal prev must not fire
    rearm = 1'b1;
    run_frame(P_FALL, 0, 128, 1'b1, 112, 2000, -1, -1);

    // constant 200 never crosses 128; then async reset mid-cycle while armed
    rearm = 1'b1;
    run_frame(P_CONST, 0, 128, 1'b0, -1, 1000, -1, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", int'(cap_if.wr_en), 0);
    chk("arst_busy", int'(cap_if.busy), 0);
    chk("arst_triggered", int'(cap_if.triggered), 0);
    chk("arst_frame_done", int'(cap_if.frame_done), 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(P_RAMP, 0, 128, 1'b0, 128, 2000, -1, -1);

    // run dropped in POST: IDLE next clk and no further writes
    rearm = 1'b1;
    run_frame(P_RAMP, 0, 128, 1'b0, 128, 2000, -1, 300);
    repeat (20) @(negedge clk);
    #1;
    chk("post_abort_sb", sb_q.size(), 0);
    chk("post_abort_done", int'(cap_if.frame_done), 0);
    chk("post_abort_busy", int'(cap_if.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
